// File: rtl/i2c_regbank_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_regbank_sync
// Desc     : CLK-synchronous I2C target register bank with RO status window.
//            Optional SCL-low timeout built when I2C_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_regbank_sync #(
    parameter logic [6:0]            DEV_ADDR       = 7'h55,
    parameter int                    NUM_REGS       = 32,
    parameter int                    NUM_RO         = 2,
    parameter logic [NUM_REGS*8-1:0] RESET_VALUE    = '0,
    parameter int                    SYNC_STAGES    = 2,
    parameter int                    GLITCH_CYCLES  = 3,
    parameter int                    TIMEOUT_CYCLES = 65535
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  SCL_IN,
    input  logic                                  SDA_IN,
    output logic                                  SDA_OE,
    output logic [NUM_REGS*8-1:0]                 o_regs,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*8-1:0] i_ro_regs,
    output logic                                  o_wr_strobe,
    output logic [7:0]                            o_wr_index,
    output logic                                  o_busy
);

    localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_IDX    = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_READ   = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_f_q, sda_f_q;
    logic [GW-1:0]          scl_cnt_q, sda_cnt_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   w_scl_s, w_sda_s;
    logic                   w_scl_rise, w_scl_fall, w_start, w_stop;
    logic                   w_timeout;

    logic [2:0] state_q, state_d;
    logic [3:0] bc_q, bc_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       mack_q, mack_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       strobe_q, strobe_d;
    logic [7:0] wr_index_q, wr_index_d;
    logic       w_wr_en;
    logic       w_ptr_in_rw;
    logic [7:0] w_rd_byte;

    logic [7:0] regs_q [NUM_REGS];

    // Bus idles high, so synchronisers and filters reset to 1
    always_ff @(posedge CLK) begin
        if (RST) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL_IN};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDA_IN};
        end
    end

    assign w_scl_s = scl_sync_q[SYNC_STAGES-1];
    assign w_sda_s = sda_sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f_q;
            sda_prev_q <= sda_f_q;
            if (w_scl_s == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == GW'(GLITCH_CYCLES - 1)) begin
                scl_f_q   <= w_scl_s;
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 1'b1;
            end
            if (w_sda_s == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == GW'(GLITCH_CYCLES - 1)) begin
                sda_f_q   <= w_sda_s;
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + 1'b1;
            end
        end
    end

    assign w_scl_rise = scl_f_q & ~scl_prev_q;
    assign w_scl_fall = ~scl_f_q & scl_prev_q;
    assign w_start    = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
    assign w_stop     = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;

`ifdef I2C_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST || !busy_q || scl_f_q || w_scl_rise) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != TW'(TIMEOUT_CYCLES)) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign w_timeout = busy_q && (to_cnt_q == TW'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_ptr_in_rw = ({1'b0, ptr_q} < 9'(NUM_REGS));

    // Read source: RW bank, then RO window, else zero
    always_comb begin
        w_rd_byte = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ptr_q == 8'(k)) begin
                w_rd_byte = regs_q[k];
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (ptr_q == 8'(NUM_REGS + j)) begin
                w_rd_byte = i_ro_regs[j*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bc_d       = bc_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        mack_d     = mack_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        strobe_d   = 1'b0;
        wr_index_d = wr_index_q;
        w_wr_en    = 1'b0;

        if (w_start) begin
            state_d  = ST_ADDR;
            sda_oe_d = 1'b0;
            bc_d     = 4'd0;
        end else if (w_stop) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            bc_d     = 4'd0;
        end else if (w_timeout) begin
            state_d  = ST_IGNORE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            bc_d     = 4'd0;
        end else if (w_scl_rise) begin
            // bc counts SCL rises: 1..8 data bits, 9 is the acknowledge clock
            if (state_q != ST_IDLE && state_q != ST_IGNORE) begin
                if (bc_q < 4'd8) begin
                    shift_d = {shift_q[6:0], sda_f_q};
                    bc_d    = bc_q + 4'd1;
                end else if (bc_q == 4'd8) begin
                    mack_d = ~sda_f_q;
                    bc_d   = 4'd9;
                end
            end
        end else if (w_scl_fall) begin
            case (state_q)
                ST_ADDR: begin
                    if (bc_q == 4'd8) begin
                        if (shift_q[7:1] == DEV_ADDR) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end else if (bc_q == 4'd9) begin
                        bc_d = 4'd0;
                        if (rw_q) begin
                            state_d  = ST_READ;
                            tx_d     = w_rd_byte;
                            sda_oe_d = ~w_rd_byte[7];
                            ptr_d    = ptr_q + 8'd1;
                        end else begin
                            state_d  = ST_IDX;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_IDX: begin
                    if (bc_q == 4'd8) begin
                        ptr_d    = shift_q;
                        sda_oe_d = 1'b1;
                    end else if (bc_q == 4'd9) begin
                        sda_oe_d = 1'b0;
                        bc_d     = 4'd0;
                        state_d  = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (bc_q == 4'd8) begin
                        if (w_ptr_in_rw) begin
                            sda_oe_d   = 1'b1;
                            w_wr_en    = 1'b1;
                            strobe_d   = 1'b1;
                            wr_index_d = ptr_q;
                        end
                        ptr_d = ptr_q + 8'd1;
                    end else if (bc_q == 4'd9) begin
                        sda_oe_d = 1'b0;
                        bc_d     = 4'd0;
                    end
                end
                ST_READ: begin
                    if (bc_q >= 4'd1 && bc_q <= 4'd7) begin
                        tx_d     = {tx_q[6:0], 1'b0};
                        sda_oe_d = ~tx_q[6];
                    end else if (bc_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                    end else if (bc_q == 4'd9) begin
                        bc_d = 4'd0;
                        if (mack_q) begin
                            tx_d     = w_rd_byte;
                            sda_oe_d = ~w_rd_byte[7];
                            ptr_d    = ptr_q + 8'd1;
                        end else begin
                            state_d  = ST_IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            bc_q       <= 4'd0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            ptr_q      <= 8'h00;
            rw_q       <= 1'b0;
            mack_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            strobe_q   <= 1'b0;
            wr_index_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            bc_q       <= bc_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            mack_q     <= mack_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            strobe_q   <= strobe_d;
            wr_index_q <= wr_index_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VALUE[k*8 +: 8];
            end
        end else if (w_wr_en) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (ptr_q == 8'(k)) begin
                    regs_q[k] <= shift_q;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_oregs
            assign o_regs[k*8 +: 8] = regs_q[k];
        end
    endgenerate

    assign SDA_OE      = sda_oe_q;
    assign o_wr_strobe = strobe_q;
    assign o_wr_index  = wr_index_q;
    assign o_busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_regbank_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_regbank_sync
// Desc     : Open-drain I2C master model with write/read scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_regbank_sync;

    localparam int NREG = 32;
    localparam int Q    = 12;
    localparam int TOUT = 65535;

    function automatic logic [NREG*8-1:0] mk_rv();
        logic [NREG*8-1:0] v;
        for (int k = 0; k < NREG; k++) v[k*8 +: 8] = 8'(8'h10 + k);
        return v;
    endfunction

    localparam logic [NREG*8-1:0] RV = mk_rv();

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              scl_m = 1'b1;
    logic              sda_m = 1'b1;
    logic [15:0]       ro = 16'hBEEF;
    logic              SDA_OE;
    logic [NREG*8-1:0] o_regs;
    logic              o_wr_strobe;
    logic [7:0]        o_wr_index;
    logic              o_busy;
    wire               sda_line = sda_m & ~SDA_OE;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_wr_q [$];
    logic [7:0]  exp_rd_q [$];
    logic [7:0]  got_rd_q [$];
    logic [NREG*8-1:0] shadow = RV;
    logic oe_watch = 1'b0;
    int   oe_hits = 0;

    i2c_regbank_sync #(
        .DEV_ADDR       (7'h55),
        .NUM_REGS       (NREG),
        .NUM_RO         (2),
        .RESET_VALUE    (RV),
        .SYNC_STAGES    (2),
        .GLITCH_CYCLES  (3),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SCL_IN      (scl_m),
        .SDA_IN      (sda_line),
        .SDA_OE      (SDA_OE),
        .o_regs      (o_regs),
        .i_ro_regs   (ro),
        .o_wr_strobe (o_wr_strobe),
        .o_wr_index  (o_wr_index),
        .o_busy      (o_busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk1(input string nm, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0b required=%0b", nm, act, req);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%02h required=%02h", nm, act, req);
        end
    endtask

    task automatic chkv(input string nm, input logic [NREG*8-1:0] act, input logic [NREG*8-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic exp_wr(input logic [7:0] idx, input logic [7:0] dat);
        exp_wr_q.push_back({idx, dat});
        shadow[int'(idx)*8 +: 8] = dat;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(2*Q);
        sda_m = 1'b0; wait_clk(2*Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(2*Q);
        sda_m = 1'b1; wait_clk(2*Q);
    endtask

    // A glitch inverts SDA for exactly one CLK in the middle of the SCL-high phase
    task automatic write_bit(input logic b, input logic glitch);
        wait_clk(Q);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        if (glitch) begin
            wait_clk(Q);
            sda_m = ~b;
            wait_clk(1);
            sda_m = b;
            wait_clk(Q-1);
        end else begin
            wait_clk(2*Q);
        end
        scl_m = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1;
        wait_clk(2*Q);
        scl_m = 1'b1;
        wait_clk(2*Q-1);
        b = sda_line;
        wait_clk(1);
        scl_m = 1'b0;
    endtask

    task automatic send_chk(input logic [7:0] b, input logic req_ack, input string nm, input int gbit);
        logic r;
        for (int i = 7; i >= 0; i--) write_bit(b[i], i == gbit);
        read_bit(r);
        chk1(nm, ~r, req_ack);
    endtask

    task automatic recv_byte(input logic [7:0] req, input logic mack, input logic chg, input logic [15:0] ro_new);
        logic [7:0] b;
        logic r;
        exp_rd_q.push_back(req);
        for (int i = 7; i >= 0; i--) begin
            if (chg && i == 4) ro = ro_new;
            read_bit(r);
            b[i] = r;
        end
        got_rd_q.push_back(b);
        write_bit(~mack, 1'b0);
    endtask

    // Write-strobe monitor
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge CLK);
            if (o_wr_strobe === 1'b1) begin
                chk1("wr_strobe_expected", exp_wr_q.size() != 0, 1'b1);
                if (exp_wr_q.size() != 0) begin
                    e = exp_wr_q.pop_front();
                    chk8("wr_index", o_wr_index, e[15:8]);
                    chk8("wr_data", o_regs[int'(o_wr_index)*8 +: 8], e[7:0]);
                end
            end
        end
    end

    // Read-data monitor
    initial begin
        logic [7:0] g;
        forever begin
            @(negedge CLK);
            if (got_rd_q.size() != 0) begin
                g = got_rd_q.pop_front();
                chk1("rd_expected", exp_rd_q.size() != 0, 1'b1);
                if (exp_rd_q.size() != 0) chk8("rd_data", g, exp_rd_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (oe_watch && SDA_OE) oe_hits++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dat;
        logic       seen;
        logic       r;

        wait_clk(4);
        chk1("rst_sda_oe", SDA_OE, 1'b0);
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_strobe", o_wr_strobe, 1'b0);
        chk8("rst_wr_index", o_wr_index, 8'h00);
        chkv("rst_regs", o_regs, RV);
        RST = 1'b0;
        wait_clk(10);

        // Basic write with auto-increment
        i2c_start();
        send_chk(8'hAA, 1'b1, "w1_addr_ack", -1);
        send_chk(8'h03, 1'b1, "w1_idx_ack", -1);
        exp_wr(8'h03, 8'h57);
        send_chk(8'h57, 1'b1, "w1_d0_ack", -1);
        exp_wr(8'h04, 8'h12);
        send_chk(8'h12, 1'b1, "w1_d1_ack", -1);
        chk1("w1_busy", o_busy, 1'b1);
        i2c_stop();
        wait_clk(10);
        chk1("w1_busy_after_stop", o_busy, 1'b0);
        chk8("w1_reg3", o_regs[31:24], 8'h57);
        chk8("w1_reg4", o_regs[39:32], 8'h12);

        // Read across RW/RO boundary; RO changes mid-byte but snapshot holds
        i2c_start();
        send_chk(8'hAA, 1'b1, "r1_addr_ack", -1);
        send_chk(8'h1F, 1'b1, "r1_idx_ack", -1);
        i2c_start();
        send_chk(8'hAB, 1'b1, "r1_raddr_ack", -1);
        recv_byte(8'h2F, 1'b1, 1'b0, 16'h0000);
        recv_byte(8'hEF, 1'b1, 1'b0, 16'h0000);
        recv_byte(8'hBE, 1'b0, 1'b1, 16'h1234);
        wait_clk(10);
        chk1("r1_released_after_nack", SDA_OE, 1'b0);
        i2c_stop();

        // Read back the earlier writes
        i2c_start();
        send_chk(8'hAA, 1'b1, "r2_addr_ack", -1);
        send_chk(8'h03, 1'b1, "r2_idx_ack", -1);
        i2c_start();
        send_chk(8'hAB, 1'b1, "r2_raddr_ack", -1);
        recv_byte(8'h57, 1'b1, 1'b0, 16'h0000);
        recv_byte(8'h12, 1'b0, 1'b0, 16'h0000);
        i2c_stop();

        // Foreign address: never drive SDA
        oe_watch = 1'b1;
        i2c_start();
        send_chk(8'hA8, 1'b0, "a8_addr_nack", -1);
        chk1("a8_busy", o_busy, 1'b0);
        send_chk(8'h00, 1'b0, "a8_b1_nack", -1);
        send_chk(8'h99, 1'b0, "a8_b2_nack", -1);
        i2c_stop();
        oe_watch = 1'b0;
        chk1("a8_never_driven", oe_hits == 0, 1'b1);
        chkv("a8_regs_unchanged", o_regs, shadow);

        // Out-of-range write is NACKed, no strobe
        i2c_start();
        send_chk(8'hAA, 1'b1, "oor_addr_ack", -1);
        send_chk(8'h40, 1'b1, "oor_idx_ack", -1);
        send_chk(8'h77, 1'b0, "oor_data_nack", -1);
        i2c_stop();

        // Pointer wraps 0xFF -> 0x00
        i2c_start();
        send_chk(8'hAA, 1'b1, "wrap_addr_ack", -1);
        send_chk(8'hFF, 1'b1, "wrap_idx_ack", -1);
        send_chk(8'h61, 1'b0, "wrap_ff_nack", -1);
        exp_wr(8'h00, 8'h62);
        send_chk(8'h62, 1'b1, "wrap_00_ack", -1);
        i2c_stop();

        // One-CLK SDA glitches while SCL high: false START then false STOP
        i2c_start();
        send_chk(8'hAA, 1'b1, "gl_addr_ack", -1);
        send_chk(8'h05, 1'b1, "gl_idx_ack", -1);
        exp_wr(8'h05, 8'hC3);
        send_chk(8'hC3, 1'b1, "gl_start_ack", 7);
        exp_wr(8'h06, 8'h3C);
        send_chk(8'h3C, 1'b1, "gl_stop_ack", 7);
        i2c_stop();
        chkv("gl_regs", o_regs, shadow);

        // RO byte 1 then beyond the window reads zero
        i2c_start();
        send_chk(8'hAA, 1'b1, "ro_addr_ack", -1);
        send_chk(8'h21, 1'b1, "ro_idx_ack", -1);
        i2c_start();
        send_chk(8'hAB, 1'b1, "ro_raddr_ack", -1);
        recv_byte(8'h12, 1'b1, 1'b0, 16'h0000);
        recv_byte(8'h00, 1'b0, 1'b0, 16'h0000);
        i2c_stop();

        // Reset while the target drives ACK
        i2c_start();
        send_chk(8'hAA, 1'b1, "rk_addr_ack", -1);
        send_chk(8'h06, 1'b1, "rk_idx_ack", -1);
        dat = 8'h9A;
        exp_wr(8'h06, dat);
        for (int i = 7; i >= 0; i--) write_bit(dat[i], 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (SDA_OE) seen = 1'b1;
        end
        chk1("rk_ack_driven", seen, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        chk1("rk_sda_oe", SDA_OE, 1'b0);
        chk1("rk_busy", o_busy, 1'b0);
        chkv("rk_regs", o_regs, RV);
        RST = 1'b0;
        shadow = RV;
        i2c_stop();
        wait_clk(10);

        // Post-reset read of reg6 returns its reset value
        i2c_start();
        send_chk(8'hAA, 1'b1, "pr_addr_ack", -1);
        send_chk(8'h06, 1'b1, "pr_idx_ack", -1);
        i2c_start();
        send_chk(8'hAB, 1'b1, "pr_raddr_ack", -1);
        recv_byte(8'h16, 1'b0, 1'b0, 16'h0000);
        i2c_stop();

`ifdef I2C_TIMEOUT_EN
        i2c_start();
        send_chk(8'hAA, 1'b1, "to_addr_ack", -1);
        send_chk(8'h00, 1'b1, "to_idx_ack", -1);
        i2c_start();
        send_chk(8'hAB, 1'b1, "to_raddr_ack", -1);
        for (int i = 0; i < 3; i++) read_bit(r);
        chk1("to_busy_before", o_busy, 1'b1);
        wait_clk(TOUT + 20);
        chk1("to_sda_released", SDA_OE, 1'b0);
        chk1("to_busy_cleared", o_busy, 1'b0);
        i2c_stop();
`else
        r = 1'b0;
`endif

        wait_clk(20);
        chk1("wr_queue_drained", exp_wr_q.size() == 0, 1'b1);
        chk1("rd_queue_drained", exp_rd_q.size() == 0, 1'b1);
        chkv("final_regs", o_regs, shadow);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
